// File: rtl/deci32_accum.sv
// deci32_accum: captures DSD L/R histories and sequences deci32_rom through a 16-cycle
// multiply-free FIR pass per channel, producing one saturated PCM sample every DECIM bits.
module deci32_accum #(
    parameter int DECIM     = 32,
    parameter int ACC_W     = 36,
    parameter int OUT_W     = 32,
    parameter int OUT_SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    dsd_en,
    input  logic                    dsd_l,
    input  logic                    dsd_r,
    output logic [3:0]              rom_addr,
    output logic [9:0]              rom_x,
    output logic [9:0]              rom_y,
    input  logic signed [31:0]      tap_left0,
    input  logic signed [31:0]      tap_left1,
    input  logic signed [31:0]      tap_left2,
    input  logic signed [31:0]      tap_left3,
    input  logic signed [31:0]      tap_left4,
    input  logic signed [31:0]      tap_left5,
    input  logic signed [31:0]      tap_left6,
    input  logic signed [31:0]      tap_left7,
    input  logic signed [31:0]      tap_left8,
    input  logic signed [31:0]      tap_left9,
    input  logic signed [31:0]      tap_right0,
    input  logic signed [31:0]      tap_right1,
    input  logic signed [31:0]      tap_right2,
    input  logic signed [31:0]      tap_right3,
    input  logic signed [31:0]      tap_right4,
    input  logic signed [31:0]      tap_right5,
    input  logic signed [31:0]      tap_right6,
    input  logic signed [31:0]      tap_right7,
    input  logic signed [31:0]      tap_right8,
    input  logic signed [31:0]      tap_right9,
    output logic signed [OUT_W-1:0] pcm_l,
    output logic signed [OUT_W-1:0] pcm_r,
    output logic                    pcm_valid,
    output logic                    busy,
    output logic                    overrun
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_t;
    localparam int CW = $clog2(DECIM);
    localparam logic signed [ACC_W-1:0] MAX_V = (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    // Only 159 bits are stored: the 160th is the incoming bit, folded in at snapshot time
    logic [158:0]              hist_l_q, hist_l_d, hist_r_q, hist_r_d;
    logic [159:0]              cur_l, cur_r, snap_l_q, snap_r_q;
    logic [3:0]                idx_q, idx_d, rom_addr_q, rom_addr_d;
    logic [9:0]                rom_x_q, rom_x_d, rom_y_q, rom_y_d;
    logic [7:0]                base;
    logic                      snap_edge, start, acc_en_q, first_q, pcm_valid_q, overrun_q;
    logic signed [31:0]        tl [10];
    logic signed [31:0]        tr [10];
    logic signed [ACC_W-1:0]   part_l, part_r, acc_l_q, acc_r_q;
    logic signed [OUT_W-1:0]   pcm_l_q, pcm_r_q;

    assign tl = '{tap_left0, tap_left1, tap_left2, tap_left3, tap_left4,
                  tap_left5, tap_left6, tap_left7, tap_left8, tap_left9};
    assign tr = '{tap_right0, tap_right1, tap_right2, tap_right3, tap_right4,
                  tap_right5, tap_right6, tap_right7, tap_right8, tap_right9};

    assign cur_l     = {hist_l_q, dsd_l};
    assign cur_r     = {hist_r_q, dsd_r};
    assign snap_edge = dsd_en && (cnt_q == CW'(DECIM - 1));
    assign start     = snap_edge && (state_q == IDLE);
    assign base      = 8'(idx_q) * 8'd10;

    assign rom_addr  = rom_addr_q;
    assign rom_x     = rom_x_q;
    assign rom_y     = rom_y_q;
    assign pcm_l     = pcm_l_q;
    assign pcm_r     = pcm_r_q;
    assign pcm_valid = pcm_valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> OUT_SHIFT;
        return (s > MAX_V) ? MAX_V[OUT_W-1:0] : (s < MIN_V) ? MIN_V[OUT_W-1:0] : s[OUT_W-1:0];
    endfunction

    always_comb begin
        part_l = '0;
        part_r = '0;
        for (int k = 0; k < 10; k++) begin
            part_l = part_l + ACC_W'(tl[k]);
            part_r = part_r + ACC_W'(tr[k]);
        end
    end

    always_comb begin
        cnt_d      = !dsd_en ? cnt_q : (cnt_q == CW'(DECIM - 1)) ? '0 : cnt_q + CW'(1);
        hist_l_d   = dsd_en ? cur_l[158:0] : hist_l_q;
        hist_r_d   = dsd_en ? cur_r[158:0] : hist_r_q;
        state_d    = state_q;
        idx_d      = idx_q;
        rom_addr_d = rom_addr_q;
        rom_x_d    = rom_x_q;
        rom_y_d    = rom_y_q;
        case (state_q)
            IDLE: begin
                state_d = start ? RUN : IDLE;
                idx_d   = '0;
            end
            RUN: begin
                rom_addr_d = idx_q;
                rom_x_d    = snap_l_q[base +: 10];
                rom_y_d    = snap_r_q[base +: 10];
                idx_d      = idx_q + 4'd1;
                state_d    = (idx_q == 4'd15) ? FLUSH : RUN;
            end
            FLUSH:   state_d = OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hist_l_q    <= '0;
            hist_r_q    <= '0;
            snap_l_q    <= '0;
            snap_r_q    <= '0;
            idx_q       <= '0;
            rom_addr_q  <= '0;
            rom_x_q     <= '0;
            rom_y_q     <= '0;
            acc_en_q    <= 1'b0;
            first_q     <= 1'b0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            pcm_l_q     <= '0;
            pcm_r_q     <= '0;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hist_l_q    <= hist_l_d;
            hist_r_q    <= hist_r_d;
            if (start) begin
                snap_l_q <= cur_l;
                snap_r_q <= cur_r;
            end
            idx_q       <= idx_d;
            rom_addr_q  <= rom_addr_d;
            rom_x_q     <= rom_x_d;
            rom_y_q     <= rom_y_d;
            // ROM output lags the address register by one cycle, so accumulation does too
            acc_en_q    <= (state_q == RUN);
            first_q     <= (state_q == RUN) && (idx_q == 4'd0);
            if (acc_en_q) begin
                acc_l_q <= first_q ? part_l : acc_l_q + part_l;
                acc_r_q <= first_q ? part_r : acc_r_q + part_r;
            end
            if (state_q == OUT) begin
                pcm_l_q <= sat(acc_l_q);
                pcm_r_q <= sat(acc_r_q);
            end
            pcm_valid_q <= (state_q == OUT);
            if (snap_edge && state_q != IDLE) overrun_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_deci32_accum.sv
// tb_deci32_accum: drives DSD streams into two deci32_accum instances (default and 24-bit/no-shift),
// models deci32_rom behaviourally, and scoreboards every PCM sample against a golden FIR model.
module tb_deci32_accum;
    logic clk = 1'b0, rst_n = 1'b0, dsd_en = 1'b0, dsd_l = 1'b0, dsd_r = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]         addr_a, addr_b;
    logic [9:0]         x_a, y_a, x_b, y_b;
    logic signed [31:0] tl_a [10], tr_a [10], tl_b [10], tr_b [10];
    logic signed [31:0] pl_a, pr_a;
    logic signed [23:0] pl_b, pr_b;
    logic               pv_a, pv_b, busy_a, busy_b, ovr_a, ovr_b;

    function automatic longint coef(input int j);
        return 64'(16 * ((j + 1) * 6000 + (j % 7) * 3 - 5));
    endfunction

    function automatic logic signed [31:0] rom_tap(input logic [3:0] a, input int k, input logic b);
        longint c;
        c = coef(int'(a) * 10 + k);
        return 32'(b ? c : -c);
    endfunction

    always_comb begin
        for (int k = 0; k < 10; k++) begin
            tl_a[k] = rom_tap(addr_a, k, x_a[k]);
            tr_a[k] = rom_tap(addr_a, k, y_a[k]);
            tl_b[k] = rom_tap(addr_b, k, x_b[k]);
            tr_b[k] = rom_tap(addr_b, k, y_b[k]);
        end
    end

    deci32_accum dut (
        .clk(clk), .rst_n(rst_n), .dsd_en(dsd_en), .dsd_l(dsd_l), .dsd_r(dsd_r),
        .rom_addr(addr_a), .rom_x(x_a), .rom_y(y_a),
        .tap_left0(tl_a[0]), .tap_left1(tl_a[1]), .tap_left2(tl_a[2]), .tap_left3(tl_a[3]),
        .tap_left4(tl_a[4]), .tap_left5(tl_a[5]), .tap_left6(tl_a[6]), .tap_left7(tl_a[7]),
        .tap_left8(tl_a[8]), .tap_left9(tl_a[9]),
        .tap_right0(tr_a[0]), .tap_right1(tr_a[1]), .tap_right2(tr_a[2]), .tap_right3(tr_a[3]),
        .tap_right4(tr_a[4]), .tap_right5(tr_a[5]), .tap_right6(tr_a[6]), .tap_right7(tr_a[7]),
        .tap_right8(tr_a[8]), .tap_right9(tr_a[9]),
        .pcm_l(pl_a), .pcm_r(pr_a), .pcm_valid(pv_a), .busy(busy_a), .overrun(ovr_a)
    );

    deci32_accum #(.OUT_W(24), .OUT_SHIFT(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .dsd_en(dsd_en), .dsd_l(dsd_l), .dsd_r(dsd_r),
        .rom_addr(addr_b), .rom_x(x_b), .rom_y(y_b),
        .tap_left0(tl_b[0]), .tap_left1(tl_b[1]), .tap_left2(tl_b[2]), .tap_left3(tl_b[3]),
        .tap_left4(tl_b[4]), .tap_left5(tl_b[5]), .tap_left6(tl_b[6]), .tap_left7(tl_b[7]),
        .tap_left8(tl_b[8]), .tap_left9(tl_b[9]),
        .tap_right0(tr_b[0]), .tap_right1(tr_b[1]), .tap_right2(tr_b[2]), .tap_right3(tr_b[3]),
        .tap_right4(tr_b[4]), .tap_right5(tr_b[5]), .tap_right6(tr_b[6]), .tap_right7(tr_b[7]),
        .tap_right8(tr_b[8]), .tap_right9(tr_b[9]),
        .pcm_l(pl_b), .pcm_r(pr_b), .pcm_valid(pv_b), .busy(busy_b), .overrun(ovr_b)
    );

    typedef struct { longint l, r, ls, rs; } exp_t;
    typedef struct { logic [159:0] hl, hr; longint exp_l, exp_r, exp_ls; } vec_t;

    exp_t         q[$];
    vec_t         vecs[6];
    logic [159:0] sh_l, sh_r;
    int           sh_cnt, errs = 0, checks = 0;
    longint       total_s, sym[2];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint model(input logic [159:0] h);
        longint s = 0;
        for (int j = 0; j < 160; j++) s += h[j] ? coef(j) : -coef(j);
        return s;
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx = (64'sd1 <<< (w - 1)) - 1;
        return (v > mx) ? mx : (v < -mx - 1) ? -mx - 1 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bit(input logic l, input logic r);
        exp_t e;
        dsd_en = 1'b1;
        dsd_l  = l;
        dsd_r  = r;
        tick();
        sh_l = {sh_l[158:0], l};
        sh_r = {sh_r[158:0], r};
        sh_cnt = (sh_cnt == 31) ? 0 : sh_cnt + 1;
        if (sh_cnt == 0) begin
            e.l  = sat(model(sh_l) >>> 4, 32);
            e.r  = sat(model(sh_r) >>> 4, 32);
            e.ls = sat(model(sh_l), 24);
            e.rs = sat(model(sh_r), 24);
            q.push_back(e);
        end
    endtask

    task automatic model_reset();
        q.delete();
        sh_l = '0;
        sh_r = '0;
        sh_cnt = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk(name, q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (pv_a) begin
            if (q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_pcm_l", pl_a, e.l);
                chk("sb_pcm_r", pr_a, e.r);
                chk("sb_sat_valid", pv_b, 1);
                chk("sb_sat_l", pl_b, e.ls);
                chk("sb_sat_r", pr_b, e.rs);
            end
        end
    end

    initial begin
        int n, vc;
        logic [159:0] one_at79, one_at0;
        model_reset();
        total_s  = model('1);
        one_at79 = 160'd1 << 79;
        one_at0  = 160'd1;
        vecs[0] = '{'1, '1, 0, 0, 0};
        vecs[1] = '{'0, '0, 0, 0, 0};
        vecs[2] = '{one_at79, one_at0, 0, 0, 0};
        vecs[3] = '{one_at0, one_at79, 0, 0, 0};
        vecs[4] = '{{$urandom, $urandom, $urandom, $urandom, $urandom}, '0, 0, 0, 0};
        vecs[5] = '{'1, '0, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            vecs[i].exp_l  = sat(model(vecs[i].hl) >>> 4, 32);
            vecs[i].exp_r  = sat(model(vecs[i].hr) >>> 4, 32);
            vecs[i].exp_ls = sat(model(vecs[i].hl), 24);
        end

        repeat (3) tick();
        chk("rst_pcm_l", pl_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", pv_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_overrun", ovr_a, 0);
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 32; t++) push_bit(1'b1, 1'b0);
        dsd_en = 1'b0;
        chk("lat_busy_e0", busy_a, 1);
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k <= 16) chk($sformatf("lat_addr_e%0d", k), addr_a, k - 1);
            chk($sformatf("lat_busy_e%0d", k), busy_a, (k <= 17) ? 1 : 0);
            chk($sformatf("lat_valid_e%0d", k), pv_a, (k == 18) ? 1 : 0);
        end
        drain("lat_drain");

        for (int i = 0; i < 6; i++) begin
            for (int t = 0; t < 160; t++) push_bit(vecs[i].hl[159 - t], vecs[i].hr[159 - t]);
            dsd_en = 1'b0;
            drain($sformatf("vec%0d_drain", i));
            chk($sformatf("vec%0d_pcm_l", i), pl_a, vecs[i].exp_l);
            chk($sformatf("vec%0d_pcm_r", i), pr_a, vecs[i].exp_r);
            chk($sformatf("vec%0d_sat_l", i), pl_b, vecs[i].exp_ls);
            if (i == 0) chk("acc_all_ones", dut.acc_l_q, total_s);
            if (i < 2) sym[i] = pl_a;
        end
        chk("sym_negate", sym[0] + sym[1], 0);
        chk("chan_indep", longint'(pl_a) + longint'(pr_a), 0);
        chk("sat_max", vecs[0].exp_ls, 8388607);
        chk("sat_min", vecs[1].exp_ls, -8388608);

        for (int t = 0; t < 32; t++) push_bit(1'b0, 1'b1);
        dsd_en = 1'b0;
        repeat (8) tick();
        chk("mid_busy_before", busy_a, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_busy", busy_a, 0);
        chk("mid_pcm_l", pl_a, 0);
        chk("mid_addr", addr_a, 0);
        chk("mid_rom_x", x_a, 0);
        vc = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (k == 2) rst_n = 1'b1;
            vc += pv_a;
        end
        chk("mid_no_valid", vc, 0);

        for (int t = 0; t < 32; t++) push_bit(t[0], ~t[0]);
        dsd_en = 1'b0;
        n = 0;
        while (!pv_a && n < 40) begin
            tick();
            n++;
        end
        chk("post_rst_latency", n, 18);
        drain("post_rst_drain");
        chk("overrun_clear", ovr_a, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
